addr_map_cfg: RTL and testbench

Runtime-programmable address-map controller that configures an `addr_decode` instance. Software-side writes land in a shadow rule array. A commit request starts a sequential validation pass, checking one rule per cycle. Only a fully valid shadow map is copied atomically into the active map that drives `addr_decode.addr_map_i`, so the decoder never sees a half-written or illegal map.

---
 rtl/addr_map_cfg_pkg.sv | 32 +++
 rtl/addr_map_cfg.sv | 131 +++++++++++++
 tb/tb_addr_map_cfg.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/addr_map_cfg_pkg.sv
// Shared types for the address-map controller: request opcodes, error codes, FSM states
// and the default rule layout matching addr_decode.
package addr_map_cfg_pkg;

   typedef enum logic [1:0] {
      OP_WRITE  = 2'd0,
      OP_COMMIT = 2'd1,
      OP_CLEAR  = 2'd2
   } cfg_op_e;

   typedef enum logic [1:0] {
      ERR_NONE  = 2'd0,
      ERR_SEL   = 2'd1,
      ERR_IDX   = 2'd2,
      ERR_RANGE = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CHECK  = 2'd1,
      COMMIT = 2'd2
   } state_e;

   typedef logic [31:0] def_addr_t;

   typedef struct packed {
      logic [31:0] idx;
      def_addr_t   start_addr;
      def_addr_t   end_addr;
   } def_rule_t;

endpackage

// File: rtl/addr_map_cfg.sv
// Shadow/active address map for addr_decode: writes land in shadow, commit validates one rule per cycle
// then swaps atomically (NoRules+1 cycles); cfg_ready_o is low while checking or committing.
module addr_map_cfg
   import addr_map_cfg_pkg::*;
#(
   parameter int unsigned NoIndices    = 32'd1,
   parameter int unsigned NoRules      = 32'd1,
   parameter type         addr_t       = def_addr_t,
   parameter type         rule_t       = def_rule_t,
   parameter int unsigned GenWidth     = 8,
   parameter int unsigned RuleSelWidth = (NoRules > 1) ? $clog2(NoRules) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cfg_valid_i,
   output logic                     cfg_ready_o,
   input  cfg_op_e                  cfg_op_i,
   input  logic [RuleSelWidth-1:0]  cfg_sel_i,
   input  rule_t                    cfg_rule_i,
   output rule_t [NoRules-1:0]      addr_map_o,
   output logic                     map_valid_o,
   output logic [GenWidth-1:0]      map_gen_o,
   output logic                     done_o,
   output logic                     busy_o,
   output logic                     err_o,
   output err_code_e                err_code_o,
   output logic [RuleSelWidth-1:0]  err_rule_o
);

   state_e                    state;
   logic [RuleSelWidth-1:0]   cnt;
   rule_t [NoRules-1:0]       shadow;
   err_code_e                 chk_code;
   logic                      cfg_xfer;

   // An open-ended rule (end_addr == 0) reaches the top of the address space, so it never fails the range test.
   function automatic err_code_e rule_check(input rule_t r);
      err_code_e code;
      addr_t     s_addr;
      addr_t     e_addr;
      code   = ERR_NONE;
      s_addr = r.start_addr;
      e_addr = r.end_addr;
      if (32'(r.idx) >= NoIndices) begin
         code = ERR_IDX;
      end else if ((s_addr >= e_addr) && (e_addr != '0)) begin
         code = ERR_RANGE;
      end
      return code;
   endfunction

   assign chk_code = rule_check(shadow[cnt]);
   assign cfg_xfer = cfg_valid_i && cfg_ready_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         shadow      <= '0;
         addr_map_o  <= '0;
         map_valid_o <= 1'b0;
         map_gen_o   <= '0;
         done_o      <= 1'b0;
         busy_o      <= 1'b0;
         err_o       <= 1'b0;
         err_code_o  <= ERR_NONE;
         err_rule_o  <= '0;
         cfg_ready_o <= 1'b1;
      end else begin
         done_o <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cfg_xfer) begin
                  err_o      <= 1'b0;
                  err_code_o <= ERR_NONE;
                  case (cfg_op_i)
                     OP_WRITE: begin
                        if (32'(cfg_sel_i) < NoRules) begin
                           shadow[cfg_sel_i] <= cfg_rule_i;
                        end else begin
                           err_o      <= 1'b1;
                           err_code_o <= ERR_SEL;
                           err_rule_o <= cfg_sel_i;
                        end
                     end
                     OP_COMMIT: begin
                        state       <= CHECK;
                        cnt         <= '0;
                        busy_o      <= 1'b1;
                        cfg_ready_o <= 1'b0;
                     end
                     OP_CLEAR: begin
                        shadow <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            CHECK: begin
               if (chk_code != ERR_NONE) begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  cfg_ready_o <= 1'b1;
                  err_o       <= 1'b1;
                  err_code_o  <= chk_code;
                  err_rule_o  <= cnt;
               end else if (32'(cnt) == NoRules - 1) begin
                  state <= COMMIT;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            COMMIT: begin
               addr_map_o  <= shadow;
               map_valid_o <= 1'b1;
               map_gen_o   <= map_gen_o + 1'b1;
               done_o      <= 1'b1;
               state       <= IDLE;
               busy_o      <= 1'b0;
               cfg_ready_o <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               busy_o      <= 1'b0;
               cfg_ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addr_map_cfg.sv
// Bench for addr_map_cfg: table vectors, hand sequences and random ops against a rule-level model,
// with a behavioural addr_decode standing in for the decoder on the active map.
module tb_addr_map_cfg;
   import addr_map_cfg_pkg::*;

   localparam int unsigned NR = 4;
   localparam int unsigned NI = 4;

   typedef def_rule_t rule_t;
   typedef def_addr_t addr_t;
   typedef rule_t [NR-1:0] map_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   cfg_op_e    cfg_op = OP_WRITE;
   logic [1:0] cfg_sel = '0;
   rule_t      cfg_rule = '0;
   map_t       addr_map;
   logic       map_valid;
   logic [7:0] map_gen;
   logic       done, busy, err;
   err_code_e  err_code;
   logic [1:0] err_rule;

   addr_map_cfg #(.NoIndices(NI), .NoRules(NR), .addr_t(addr_t), .rule_t(rule_t), .GenWidth(8)) dut (
      .clk_i(clk), .rst_i(rst), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_op_i(cfg_op),
      .cfg_sel_i(cfg_sel), .cfg_rule_i(cfg_rule), .addr_map_o(addr_map), .map_valid_o(map_valid),
      .map_gen_o(map_gen), .done_o(done), .busy_o(busy), .err_o(err), .err_code_o(err_code),
      .err_rule_o(err_rule));

   // Five-rule build: 3-bit select so out-of-range slots are reachable.
   logic            v5 = 1'b0;
   logic            ready5;
   cfg_op_e         op5_s = OP_WRITE;
   logic [2:0]      sel5 = '0;
   rule_t           rule5 = '0;
   rule_t [4:0]     map5;
   logic            valid5, done5, busy5, err5;
   logic [7:0]      gen5;
   err_code_e       code5;
   logic [2:0]      erule5;

   addr_map_cfg #(.NoIndices(NI), .NoRules(5), .addr_t(addr_t), .rule_t(rule_t), .GenWidth(8)) dut5 (
      .clk_i(clk), .rst_i(rst), .cfg_valid_i(v5), .cfg_ready_o(ready5), .cfg_op_i(op5_s),
      .cfg_sel_i(sel5), .cfg_rule_i(rule5), .addr_map_o(map5), .map_valid_o(valid5),
      .map_gen_o(gen5), .done_o(done5), .busy_o(busy5), .err_o(err5), .err_code_o(code5),
      .err_rule_o(erule5));

   map_t      sh_m, act_m;
   int        gen_m;
   bit        valid_m, err_m;
   err_code_e code_m;
   int        erule_m;
   int        n_chk = 0;
   int        n_fail = 0;

   typedef struct {
      rule_t     r;
      int        slot;
      err_code_e exp_code;
      int        exp_rule;
   } vec_t;
   vec_t  vecs[7];
   map_t  base;

   function automatic rule_t mk(input int unsigned idx, input addr_t s, input addr_t e);
      rule_t r;
      r.idx = idx;
      r.start_addr = s;
      r.end_addr = e;
      return r;
   endfunction

   // Last matching rule wins; end_addr of zero means "to the top of memory".
   function automatic logic [31:0] decode(input map_t m, input addr_t a);
      logic [31:0] res;
      res = 32'd0;
      for (int i = 0; i < NR; i++)
         if (a >= m[i].start_addr && (a < m[i].end_addr || m[i].end_addr == 0)) res = m[i].idx;
      return res;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      sh_m = '0; act_m = '0; gen_m = 0; valid_m = 0; err_m = 0; code_m = ERR_NONE; erule_m = 0;
   endtask

   task automatic check_state();
      for (int i = 0; i < NR; i++) chk("active_rule", addr_map[i], act_m[i]);
      chk("map_valid", map_valid, valid_m);
      chk("map_gen", map_gen, gen_m[7:0]);
      chk("err", err, err_m);
      chk("err_code", err_code, code_m);
      chk("err_rule", err_rule, erule_m[1:0]);
   endtask

   task automatic do_op(input cfg_op_e op, input int sel, input rule_t r);
      int t;
      t = 0;
      cfg_valid = 1'b1; cfg_op = op; cfg_sel = 2'(sel); cfg_rule = r;
      while (!cfg_ready && t < 64) begin
         @(posedge clk); #1; t++;
      end
      chk("accept_wait", t < 64, 1);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      err_m = 0; code_m = ERR_NONE;
      if (op == OP_WRITE) sh_m[sel] = r;
      else if (op == OP_CLEAR) sh_m = '0;
      chk("done_idle", done, 0);
   endtask

   // Called one step after the commit-accepting edge; follows the check cycle by cycle.
   task automatic run_commit();
      err_code_e c;
      int k, steps;
      c = ERR_NONE; k = 0;
      for (int i = 0; i < NR; i++) begin
         if (c == ERR_NONE) begin
            if (sh_m[i].idx >= NI) begin c = ERR_IDX; k = i; end
            else if (sh_m[i].end_addr != 0 && sh_m[i].start_addr >= sh_m[i].end_addr) begin
               c = ERR_RANGE; k = i;
            end
         end
      end
      steps = (c == ERR_NONE) ? NR + 1 : k + 1;
      for (int t = 0; t < steps; t++) begin
         chk("busy_during", busy, 1);
         chk("ready_during", cfg_ready, 0);
         chk("done_during", done, 0);
         @(posedge clk); #1;
      end
      if (c != ERR_NONE) begin
         err_m = 1; code_m = c; erule_m = k;
      end else begin
         act_m = sh_m; gen_m++; valid_m = 1;
      end
      chk("done_end", done, c == ERR_NONE);
      chk("busy_end", busy, 0);
      chk("ready_end", cfg_ready, 1);
      check_state();
   endtask

   task automatic load_base();
      for (int i = 0; i < NR; i++) do_op(OP_WRITE, i, base[i]);
   endtask

   task automatic op5(input cfg_op_e op, input int sel, input rule_t r);
      int t;
      t = 0;
      v5 = 1'b1; op5_s = op; sel5 = 3'(sel); rule5 = r;
      while (!ready5 && t < 64) begin
         @(posedge clk); #1; t++;
      end
      chk("accept5_wait", t < 64, 1);
      @(posedge clk); #1;
      v5 = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      rule_t r;
      addr_t a;
      int p, s, e;

      base[0] = mk(1, 32'h1000, 32'h2000);
      base[1] = mk(2, 32'h2000, 32'h3000);
      base[2] = mk(3, 32'h3000, 32'h0);
      base[3] = mk(0, 32'h0, 32'h1000);
      vecs[0] = '{mk(4, 32'h3000, 32'h0), 2, ERR_IDX, 2};
      vecs[1] = '{mk(0, 32'h2000, 32'h1000), 0, ERR_RANGE, 0};
      vecs[2] = '{mk(5, 32'h2000, 32'h1000), 1, ERR_IDX, 1};
      vecs[3] = '{mk(1, 32'h5000, 32'h0), 3, ERR_NONE, 0};
      vecs[4] = '{mk(2, 32'h1000, 32'h1000), 1, ERR_RANGE, 1};
      vecs[5] = '{mk(3, 32'h0, 32'h0), 0, ERR_NONE, 0};
      vecs[6] = '{mk(3, 32'hFFFF_F000, 32'hFFFF_FFFF), 3, ERR_NONE, 0};

      #1 rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      check_state();
      chk("rst_decode_1234", decode(addr_map, 32'h1234), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Successful commit of the reference map.
      load_base();
      do_op(OP_COMMIT, 0, '0);
      run_commit();
      chk("map_gen_first", map_gen, 1);
      chk("decode_2ABC", decode(addr_map, 32'h2ABC), 2);
      chk("decode_FFFF0000", decode(addr_map, 32'hFFFF_0000), 3);

      // Table: reference map with one slot overwritten, then commit.
      foreach (vecs[v]) begin
         load_base();
         do_op(OP_WRITE, vecs[v].slot, vecs[v].r);
         do_op(OP_COMMIT, 0, '0);
         run_commit();
         chk("tbl_code", err_code, vecs[v].exp_code);
         if (vecs[v].exp_code != ERR_NONE) chk("tbl_rule", err_rule, vecs[v].exp_rule);
      end

      // Request held through CHECK/COMMIT must wait for IDLE.
      load_base();
      do_op(OP_COMMIT, 0, '0);
      cfg_valid = 1'b1; cfg_op = OP_CLEAR;
      run_commit();
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      sh_m = '0; err_m = 0; code_m = ERR_NONE;
      chk("stall_no_restart", busy, 0);
      do_op(OP_COMMIT, 0, '0);
      run_commit();
      chk("stall_cleared_map", addr_map, '0);

      // Reset in the middle of a check.
      load_base();
      do_op(OP_COMMIT, 0, '0);
      @(posedge clk); #1;
      chk("midcheck_busy", busy, 1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", cfg_ready, 1);
      chk("midrst_done", done, 0);
      check_state();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(OP_COMMIT, 0, '0);
      run_commit();

      // Select error on the five-rule build.
      op5(OP_WRITE, 1, mk(2, 32'h100, 32'h200));
      chk("sel_ok_err", err5, 0);
      op5(OP_WRITE, 5, mk(1, 32'h10, 32'h20));
      chk("sel5_err", err5, 1);
      chk("sel5_code", code5, ERR_SEL);
      chk("sel5_rule", erule5, 5);
      op5(OP_WRITE, 7, mk(3, 32'h10, 32'h20));
      chk("sel7_rule", erule5, 7);
      op5(cfg_op_e'(2'd3), 0, '0);
      chk("reserved_clears_err", err5, 0);
      op5(OP_WRITE, 6, mk(3, 32'h10, 32'h20));
      op5(OP_COMMIT, 0, '0);
      chk("sel_err_cleared", err5, 0);
      t = 0;
      while (!done5 && t < 20) begin
         @(posedge clk); #1; t++;
      end
      chk("commit5_done", done5, 1);
      chk("commit5_gen", gen5, 1);
      for (int i = 0; i < 5; i++)
         chk("shadow5_intact", map5[i], (i == 1) ? mk(2, 32'h100, 32'h200) : rule_t'('0));

      // Random operations against the model.
      for (int n = 0; n < 200; n++) begin
         p = $urandom_range(0, 9);
         if ($urandom_range(0, 4) == 0) begin
            r = mk($urandom_range(0, 6), $urandom_range(0, 15) << 12, $urandom_range(0, 15) << 12);
         end else begin
            s = $urandom_range(0, 14);
            e = $urandom_range(s + 1, 16);
            r = mk($urandom_range(0, NI - 1), s << 12, (e == 16) ? 0 : (e << 12));
         end
         if (p <= 5) do_op(OP_WRITE, $urandom_range(0, NR - 1), r);
         else if (p <= 7) begin
            do_op(OP_COMMIT, 0, '0);
            run_commit();
         end
         else if (p == 8) do_op(OP_CLEAR, 0, '0);
         else do_op(cfg_op_e'(2'd3), 0, '0);
         check_state();
         a = $urandom;
         chk("rand_decode", decode(addr_map, a), decode(act_m, a));
      end

      // Generation counter wraps after 256 commits from reset.
      rst = 1'b1;
      #1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      load_base();
      for (int n = 0; n < 256; n++) begin
         do_op(OP_COMMIT, 0, '0);
         run_commit();
      end
      chk("wrap_gen", map_gen, 0);
      chk("wrap_valid", map_valid, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
